// File: rtl/lfsr_gen.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_gen
// Purpose  : Parametrised Fibonacci LFSR with enable, seed load, zero-state
//            recovery, wrap detection and a thresholded random tick.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_gen #(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS = 8'h8E,
    parameter logic [WIDTH-1:0] SEED = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int              STEPS = 1
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_seed,
    input  logic [WIDTH-1:0] i_thresh,
    output logic [WIDTH-1:0] o_lfsr,
    output logic             o_tick,
    output logic             o_wrap,
    output logic             o_lockup
);

    localparam logic [WIDTH-1:0] c_zero = '0;

    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] r_seed;
    logic             r_tick;
    logic             r_wrap;
    logic             r_lockup;

    logic [WIDTH-1:0] w_adv;
    logic [WIDTH-1:0] w_next_lfsr;
    logic [WIDTH-1:0] w_next_seed;
    logic             w_next_tick;
    logic             w_next_wrap;
    logic             w_next_lockup;

    // STEPS single shifts chained combinationally; the loop unrolls at elaboration.
    function automatic logic [WIDTH-1:0] f_advance(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] v;
        v = s;
        for (int k = 0; k < STEPS; k++) begin
            v = {v[WIDTH-2:0], ^(v & TAPS)};
        end
        return v;
    endfunction

    assign w_adv = f_advance(r_lfsr);

    always_comb begin
        w_next_lfsr   = r_lfsr;
        w_next_seed   = r_seed;
        w_next_tick   = r_tick;
        w_next_wrap   = 1'b0;
        w_next_lockup = 1'b0;
        if (i_load) begin
            if (i_seed == c_zero) begin
                w_next_lfsr   = SEED;
                w_next_lockup = 1'b1;
            end else begin
                w_next_lfsr = i_seed;
            end
            w_next_seed = w_next_lfsr;
            w_next_tick = (w_next_lfsr < i_thresh);
        end else if (i_en) begin
            // The all-zero state is a fixed point of the shift; recover to SEED.
            if (r_lfsr == c_zero) begin
                w_next_lfsr   = SEED;
                w_next_lockup = 1'b1;
            end else begin
                w_next_lfsr = w_adv;
            end
            w_next_tick = (w_next_lfsr < i_thresh);
            w_next_wrap = (w_next_lfsr == r_seed);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_lfsr   <= SEED;
            r_seed   <= SEED;
            r_tick   <= 1'b0;
            r_wrap   <= 1'b0;
            r_lockup <= 1'b0;
        end else begin
            r_lfsr   <= w_next_lfsr;
            r_seed   <= w_next_seed;
            r_tick   <= w_next_tick;
            r_wrap   <= w_next_wrap;
            r_lockup <= w_next_lockup;
        end
    end

    assign o_lfsr   = r_lfsr;
    assign o_tick   = r_tick;
    assign o_wrap   = r_wrap;
    assign o_lockup = r_lockup;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_gen
// Purpose  : Directed, table-driven checks of lfsr_gen in 3-bit, 3-bit/2-step
//            and 8-bit configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_gen;

    typedef struct {
        logic       en;
        logic       ld;
        logic [2:0] seed;
        logic [2:0] th;
        logic [2:0] lfsr;
        logic       tick;
        logic       wrap;
        logic       lock;
    } vec_t;

    logic clk;
    logic rstn;

    logic       en3, ld3;
    logic [2:0] seed3, th3, lfsr3;
    logic       tick3, wrap3, lock3;

    logic       en2;
    logic       ld2;
    logic [2:0] seed2, th2, lfsr2;
    logic       tick2, wrap2, lock2;

    logic       en8, ld8;
    logic [7:0] seed8, th8, lfsr8;
    logic       tick8, wrap8, lock8;

    int checks = 0;
    int errors = 0;

    lfsr_gen #(.WIDTH(3), .TAPS(3'h5), .SEED(3'd1), .STEPS(1)) u_dut3 (
        .i_clk(clk), .i_rstn(rstn), .i_en(en3), .i_load(ld3), .i_seed(seed3),
        .i_thresh(th3), .o_lfsr(lfsr3), .o_tick(tick3), .o_wrap(wrap3), .o_lockup(lock3)
    );

    lfsr_gen #(.WIDTH(3), .TAPS(3'h5), .SEED(3'd1), .STEPS(2)) u_dut2 (
        .i_clk(clk), .i_rstn(rstn), .i_en(en2), .i_load(ld2), .i_seed(seed2),
        .i_thresh(th2), .o_lfsr(lfsr2), .o_tick(tick2), .o_wrap(wrap2), .o_lockup(lock2)
    );

    lfsr_gen #(.WIDTH(8), .TAPS(8'h8E), .SEED(8'h01), .STEPS(1)) u_dut8 (
        .i_clk(clk), .i_rstn(rstn), .i_en(en8), .i_load(ld8), .i_seed(seed8),
        .i_thresh(th8), .o_lfsr(lfsr8), .o_tick(tick8), .o_wrap(wrap8), .o_lockup(lock8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic en, input logic ld, input logic [2:0] seed,
                                input logic [2:0] th, input logic [2:0] lf,
                                input logic tk, input logic wr, input logic lk);
        vec_t v;
        v.en = en; v.ld = ld; v.seed = seed; v.th = th;
        v.lfsr = lf; v.tick = tk; v.wrap = wr; v.lock = lk;
        return v;
    endfunction

    vec_t vt[$];
    logic [2:0] s2_exp [7];
    logic [255:0] seen;
    int tcount;
    int distinct;

    initial begin
        rstn = 1'b0;
        en3 = 1'b0; ld3 = 1'b0; seed3 = 3'd0; th3 = 3'd0;
        en2 = 1'b0; ld2 = 1'b0; seed2 = 3'd0; th2 = 3'd0;
        en8 = 1'b0; ld8 = 1'b0; seed8 = 8'd0; th8 = 8'd0;

        // {en, load, seed, thresh} -> {lfsr, tick, wrap, lockup} for the 3-bit DUT
        vt.push_back(mk(1'b1, 1'b0, 3'd0, 3'd4, 3'd3, 1'b1, 1'b0, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 3'd0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 3'd0, 3'd4, 3'd7, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 3'd0, 3'd4, 3'd6, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 3'd0, 3'd4, 3'd5, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 3'd0, 3'd4, 3'd2, 1'b1, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 3'd0, 3'd4, 3'd4, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 3'd0, 3'd4, 3'd1, 1'b1, 1'b1, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 3'd0, 3'd4, 3'd1, 1'b1, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b1, 3'd6, 3'd7, 3'd6, 1'b1, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 3'd0, 3'd4, 3'd5, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 3'd0, 3'd4, 3'd2, 1'b1, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 3'd0, 3'd4, 3'd4, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 3'd0, 3'd4, 3'd1, 1'b1, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 3'd0, 3'd4, 3'd3, 1'b1, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 3'd0, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 3'd0, 3'd7, 3'd6, 1'b1, 1'b1, 1'b0));
        vt.push_back(mk(1'b1, 1'b1, 3'd0, 3'd4, 3'd1, 1'b1, 1'b0, 1'b1));
        vt.push_back(mk(1'b0, 1'b0, 3'd0, 3'd4, 3'd1, 1'b1, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 3'd0, 3'd0, 3'd3, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 3'd0, 3'd4, 3'd7, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 3'd0, 3'd4, 3'd6, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 3'd0, 3'd4, 3'd5, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 3'd0, 3'd4, 3'd2, 1'b1, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 3'd0, 3'd4, 3'd4, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 3'd0, 3'd4, 3'd1, 1'b1, 1'b1, 1'b0));

        s2_exp[0] = 3'd7; s2_exp[1] = 3'd5; s2_exp[2] = 3'd4; s2_exp[3] = 3'd3;
        s2_exp[4] = 3'd6; s2_exp[5] = 3'd2; s2_exp[6] = 3'd1;

        // Reset state
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        #1;
        check("rst_lfsr3", {29'd0, lfsr3}, 32'd1);
        check("rst_lfsr8", {24'd0, lfsr8}, 32'h01);
        check("rst_flags8", {29'd0, tick8, wrap8, lock8}, 32'd0);
        check("rst_flags3", {29'd0, tick3, wrap3, lock3}, 32'd0);

        // 3-bit table
        foreach (vt[i]) begin
            en3 = vt[i].en; ld3 = vt[i].ld; seed3 = vt[i].seed; th3 = vt[i].th;
            cyc();
            check($sformatf("v%0d_lfsr", i), {29'd0, lfsr3}, {29'd0, vt[i].lfsr});
            check($sformatf("v%0d_tick", i), {31'd0, tick3}, {31'd0, vt[i].tick});
            check($sformatf("v%0d_wrap", i), {31'd0, wrap3}, {31'd0, vt[i].wrap});
            check($sformatf("v%0d_lockup", i), {31'd0, lock3}, {31'd0, vt[i].lock});
        end
        en3 = 1'b0; ld3 = 1'b0;

        // 2 steps per clock
        en2 = 1'b1;
        for (int k = 0; k < 7; k++) begin
            cyc();
            check($sformatf("s2_lfsr%0d", k), {29'd0, lfsr2}, {29'd0, s2_exp[k]});
            check($sformatf("s2_wrap%0d", k), {31'd0, wrap2}, {31'd0, (k == 6)});
        end
        en2 = 1'b0;
        cyc();
        check("s2_hold_lfsr", {29'd0, lfsr2}, 32'd1);
        check("s2_hold_wrap", {31'd0, wrap2}, 32'd0);

        // 8-bit full period with thresh 0x80
        seen = '0; seen[1] = 1'b1; tcount = 0; distinct = 1;
        th8 = 8'h80; en8 = 1'b1;
        for (int k = 0; k < 255; k++) begin
            cyc();
            if (k == 0) check("p8_first0", {24'd0, lfsr8}, 32'h02);
            if (k == 1) check("p8_first1", {24'd0, lfsr8}, 32'h05);
            if (k == 2) check("p8_first2", {24'd0, lfsr8}, 32'h0B);
            check($sformatf("p8_wrap%0d", k), {31'd0, wrap8}, {31'd0, (k == 254)});
            if (k < 254) begin
                check($sformatf("p8_unique%0d", k), {31'd0, seen[lfsr8]}, 32'd0);
                if (!seen[lfsr8]) distinct++;
                seen[lfsr8] = 1'b1;
            end
            if (tick8) tcount++;
        end
        check("p8_distinct", distinct, 255);
        check("p8_zero_never", {31'd0, seen[0]}, 32'd0);
        check("p8_tick_count", tcount, 127);
        check("p8_end_state", {24'd0, lfsr8}, 32'h01);

        // Load with enable: load wins, new active seed
        ld8 = 1'b1; seed8 = 8'h5A;
        cyc();
        ld8 = 1'b0;
        check("ld_lfsr", {24'd0, lfsr8}, 32'h5A);
        check("ld_wrap", {31'd0, wrap8}, 32'd0);
        check("ld_tick", {31'd0, tick8}, 32'd1);
        th8 = 8'h00; tcount = 0;
        for (int k = 0; k < 255; k++) begin
            cyc();
            check($sformatf("s5a_wrap%0d", k), {31'd0, wrap8}, {31'd0, (k == 254)});
            if (tick8) tcount++;
        end
        check("s5a_end_state", {24'd0, lfsr8}, 32'h5A);
        check("thr0_tick_count", tcount, 0);

        // Load of zero falls back to SEED and flags lockup
        en8 = 1'b0; ld8 = 1'b1; seed8 = 8'h00; th8 = 8'h80;
        cyc();
        ld8 = 1'b0;
        check("ld0_lfsr", {24'd0, lfsr8}, 32'h01);
        check("ld0_lockup", {31'd0, lock8}, 32'd1);
        check("ld0_tick", {31'd0, tick8}, 32'd1);
        en8 = 1'b1; en3 = 1'b1; th3 = 3'd4;
        cyc();
        check("post_ld0_lfsr", {24'd0, lfsr8}, 32'h02);
        check("post_ld0_lockup", {31'd0, lock8}, 32'd0);
        check("pre_rst_lfsr3", {29'd0, lfsr3}, 32'd3);

        // Asynchronous reset between clock edges
        en8 = 1'b0; en3 = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("arst_lfsr8", {24'd0, lfsr8}, 32'h01);
        check("arst_tick8", {31'd0, tick8}, 32'd0);
        check("arst_lfsr3", {29'd0, lfsr3}, 32'd1);
        check("arst_tick3", {31'd0, tick3}, 32'd0);
        #2 rstn = 1'b1;
        en8 = 1'b1;
        cyc();
        check("restart0", {24'd0, lfsr8}, 32'h02);
        cyc();
        check("restart1", {24'd0, lfsr8}, 32'h05);
        check("restart_tick", {31'd0, tick8}, 32'd1);
        en8 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
